// File: rtl/port0_pkt_arbiter.sv
// port0_pkt_arbiter
//   Packet-level arbiter sharing the Port_0 output mux between the LCM and
//   SSM packet sources. One source is granted at a time. The grant is
//   released only on a tail word (tag 10 with data_wr) or on a stall
//   timeout. A one-cycle GAP always follows a release.
//
// Parameters
//   PRIO_MODE       0 = round-robin, 1 = LCM strict priority
//   TIMEOUT_CYCLES  stall tolerance inside a grant (>= 2)
//   CNT_WIDTH       width of the per-source packet counters
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   lcm2arb_req/ssm2arb_req  level requests (complete packet ready)
//   port_0_ready             sampled only when picking a winner in IDLE
//   mux2port_0_data_tag      word tag on mux output (01 head, 11 body, 10 tail)
//   mux2port_0_data_wr       word strobe on mux output
//   arb2lcm_grant/arb2ssm_grant  level grants
//   mux2port_0_rd            mux select, 0 = LCM, 1 = SSM
//   timeout_err              one-cycle pulse on forced release
//   stray_wr_err             one-cycle pulse on data_wr with no grant
//   lcm_pkt_cnt/ssm_pkt_cnt  completed packet counts, wrapping
module port0_pkt_arbiter #(
  parameter int PRIO_MODE      = 0,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 lcm2arb_req,
  input  logic                 ssm2arb_req,
  input  logic                 port_0_ready,
  input  logic [1:0]           mux2port_0_data_tag,
  input  logic                 mux2port_0_data_wr,
  output logic                 arb2lcm_grant,
  output logic                 arb2ssm_grant,
  output logic                 mux2port_0_rd,
  output logic                 timeout_err,
  output logic                 stray_wr_err,
  output logic [CNT_WIDTH-1:0] lcm_pkt_cnt,
  output logic [CNT_WIDTH-1:0] ssm_pkt_cnt
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // The counter would reach TIMEOUT_CYCLES-1 at the coming edge, so release
  // is decided one value early and the registered pulse lands with it.
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 2);

  typedef enum logic [1:0] {IDLE, GNT_LCM, GNT_SSM, GAP} state_t;

  state_t         state, state_nxt;
  logic           last_ssm, last_ssm_nxt;
  logic           rd_nxt;
  logic [TW-1:0]  to_cnt, to_cnt_nxt;
  logic           to_err_nxt, stray_nxt;
  logic           lcm_inc, ssm_inc;
  logic           pick_ssm, tail, to_hit;

  assign arb2lcm_grant = (state == GNT_LCM);
  assign arb2ssm_grant = (state == GNT_SSM);

  always_comb begin
    tail   = mux2port_0_data_wr && (mux2port_0_data_tag == 2'b10);
    to_hit = !mux2port_0_data_wr && (to_cnt == TO_LAST);

    if (PRIO_MODE != 0)
      pick_ssm = !lcm2arb_req;
    else if (lcm2arb_req && ssm2arb_req)
      pick_ssm = !last_ssm;
    else
      pick_ssm = ssm2arb_req;

    state_nxt    = state;
    last_ssm_nxt = last_ssm;
    rd_nxt       = mux2port_0_rd;
    to_cnt_nxt   = '0;
    to_err_nxt   = 1'b0;
    stray_nxt    = 1'b0;
    lcm_inc      = 1'b0;
    ssm_inc      = 1'b0;

    case (state)
      IDLE: begin
        stray_nxt = mux2port_0_data_wr;
        if (port_0_ready && (lcm2arb_req || ssm2arb_req)) begin
          state_nxt    = pick_ssm ? GNT_SSM : GNT_LCM;
          rd_nxt       = pick_ssm;
          last_ssm_nxt = pick_ssm;
        end
      end
      GNT_LCM, GNT_SSM: begin
        if (tail) begin
          state_nxt = GAP;
          lcm_inc   = (state == GNT_LCM);
          ssm_inc   = (state == GNT_SSM);
        end else if (to_hit) begin
          state_nxt  = GAP;
          to_err_nxt = 1'b1;
        end else if (!mux2port_0_data_wr) begin
          to_cnt_nxt = to_cnt + TW'(1);
        end
      end
      GAP: begin
        stray_nxt = mux2port_0_data_wr;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      last_ssm      <= 1'b1;
      mux2port_0_rd <= 1'b0;
      to_cnt        <= '0;
      timeout_err   <= 1'b0;
      stray_wr_err  <= 1'b0;
      lcm_pkt_cnt   <= '0;
      ssm_pkt_cnt   <= '0;
    end else begin
      state         <= state_nxt;
      last_ssm      <= last_ssm_nxt;
      mux2port_0_rd <= rd_nxt;
      to_cnt        <= to_cnt_nxt;
      timeout_err   <= to_err_nxt;
      stray_wr_err  <= stray_nxt;
      if (lcm_inc) lcm_pkt_cnt <= lcm_pkt_cnt + CNT_WIDTH'(1);
      if (ssm_inc) ssm_pkt_cnt <= ssm_pkt_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_port0_pkt_arbiter.sv
// Directed bench for port0_pkt_arbiter. dut0 runs round-robin with an
// 8-cycle timeout; dut_p runs LCM priority with 2-bit counters so the
// wrap is reachable. Both share the stimulus.
module tb_port0_pkt_arbiter;

  logic clk = 1'b0;
  logic rst, lcm_req, ssm_req, ready, wr;
  logic [1:0] tag;

  logic g_lcm0, g_ssm0, rd0, to0, st0;
  logic [15:0] lc0, sc0;
  logic g_lcm1, g_ssm1, rd1, to1, st1;
  logic [1:0] lc1, sc1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  port0_pkt_arbiter #(.PRIO_MODE(0), .TIMEOUT_CYCLES(8), .CNT_WIDTH(16)) dut0 (
    .clk(clk), .rst(rst), .lcm2arb_req(lcm_req), .ssm2arb_req(ssm_req),
    .port_0_ready(ready), .mux2port_0_data_tag(tag), .mux2port_0_data_wr(wr),
    .arb2lcm_grant(g_lcm0), .arb2ssm_grant(g_ssm0), .mux2port_0_rd(rd0),
    .timeout_err(to0), .stray_wr_err(st0), .lcm_pkt_cnt(lc0), .ssm_pkt_cnt(sc0));

  port0_pkt_arbiter #(.PRIO_MODE(1), .CNT_WIDTH(2)) dut_p (
    .clk(clk), .rst(rst), .lcm2arb_req(lcm_req), .ssm2arb_req(ssm_req),
    .port_0_ready(ready), .mux2port_0_data_tag(tag), .mux2port_0_data_wr(wr),
    .arb2lcm_grant(g_lcm1), .arb2ssm_grant(g_ssm1), .mux2port_0_rd(rd1),
    .timeout_err(to1), .stray_wr_err(st1), .lcm_pkt_cnt(lc1), .ssm_pkt_cnt(sc1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; lcm_req = 1'b0; ssm_req = 1'b0; ready = 1'b0; wr = 1'b0; tag = 2'b00;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Drives an n-word packet; returns in the cycle after the tail (GAP).
  task automatic send_pkt(input int n);
    for (int i = 0; i < n; i++) begin
      tag = (i == n - 1) ? 2'b10 : ((i == 0) ? 2'b01 : 2'b11);
      wr = 1'b1;
      tick();
    end
    wr = 1'b0;
    tag = 2'b00;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if ({g_lcm0, g_ssm0, rd0, to0, st0} !== 5'b0) begin bad++; $display("FAIL reset_flags0: got %b want 00000", {g_lcm0, g_ssm0, rd0, to0, st0}); end
    total++; if ({lc0, sc0} !== 32'h0) begin bad++; $display("FAIL reset_cnt0: got %h want 0", {lc0, sc0}); end
    total++; if ({g_lcm1, g_ssm1, rd1, to1, st1, lc1, sc1} !== 9'b0) begin bad++; $display("FAIL reset_p: got %b want 0", {g_lcm1, g_ssm1, rd1, to1, st1, lc1, sc1}); end
  endtask

  task automatic test_single_lcm();
    do_reset();
    tick();
    lcm_req = 1'b1; ready = 1'b1;
    tick();
    total++; if ({g_lcm0, g_ssm0, rd0} !== 3'b100) begin bad++; $display("FAIL t1_grant: got %b want 100", {g_lcm0, g_ssm0, rd0}); end
    lcm_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tag = (i == 5) ? 2'b10 : ((i == 0) ? 2'b01 : 2'b11);
      wr = 1'b1;
      tick();
      if (i < 5) begin
        total++; if (g_lcm0 !== 1'b1) begin bad++; $display("FAIL t1_hold w%0d: got %b want 1", i, g_lcm0); end
      end
    end
    total++; if ({g_lcm0, lc0} !== {1'b0, 16'd1}) begin bad++; $display("FAIL t1_tail: grant/cnt got %b/%0d want 0/1", g_lcm0, lc0); end
    // data_wr while in GAP is a stray write
    tag = 2'b01;
    tick();
    wr = 1'b0;
    total++; if ({st0, g_lcm0, g_ssm0} !== 3'b100) begin bad++; $display("FAIL t1_gap_stray: got %b want 100", {st0, g_lcm0, g_ssm0}); end
    tick();
    total++; if (st0 !== 1'b0) begin bad++; $display("FAIL t1_stray_pulse: got %b want 0", st0); end
  endtask

  task automatic test_back_to_back();
    logic exp_ssm;
    do_reset();
    lcm_req = 1'b1; ssm_req = 1'b1; ready = 1'b1;
    tick();
    for (int p = 0; p < 4; p++) begin
      exp_ssm = (p % 2 == 1);
      total++; if ({g_lcm0, g_ssm0, rd0} !== {!exp_ssm, exp_ssm, exp_ssm}) begin bad++; $display("FAIL rr_grant p%0d: got %b want %b", p, {g_lcm0, g_ssm0, rd0}, {!exp_ssm, exp_ssm, exp_ssm}); end
      send_pkt(3);
      total++; if ({g_lcm0, g_ssm0, rd0} !== {2'b00, exp_ssm}) begin bad++; $display("FAIL rr_gap p%0d: got %b want %b", p, {g_lcm0, g_ssm0, rd0}, {2'b00, exp_ssm}); end
      total++; if (lc0 !== 16'((p + 2) / 2) || sc0 !== 16'((p + 1) / 2)) begin bad++; $display("FAIL rr_cnt p%0d: got %0d/%0d want %0d/%0d", p, lc0, sc0, (p + 2) / 2, (p + 1) / 2); end
      if (p == 3) begin lcm_req = 1'b0; ssm_req = 1'b0; end
      tick();
      total++; if ({g_lcm0, g_ssm0} !== 2'b00) begin bad++; $display("FAIL rr_idle p%0d: got %b want 00", p, {g_lcm0, g_ssm0}); end
      tick();
    end
    total++; if ({g_lcm0, g_ssm0, rd0} !== 3'b001) begin bad++; $display("FAIL rr_end: got %b want 001", {g_lcm0, g_ssm0, rd0}); end
  endtask

  task automatic test_priority();
    do_reset();
    lcm_req = 1'b1; ssm_req = 1'b1; ready = 1'b1;
    tick();
    for (int p = 0; p < 3; p++) begin
      total++; if ({g_lcm1, g_ssm1, rd1} !== 3'b100) begin bad++; $display("FAIL prio_grant p%0d: got %b want 100", p, {g_lcm1, g_ssm1, rd1}); end
      send_pkt(2);
      if (p == 2) lcm_req = 1'b0;
      tick();
      tick();
    end
    total++; if ({g_lcm1, g_ssm1, rd1, lc1, sc1} !== {3'b011, 2'd3, 2'd0}) begin bad++; $display("FAIL prio_ssm: got %b want 0111100", {g_lcm1, g_ssm1, rd1, lc1, sc1}); end
    send_pkt(1);
    total++; if ({g_ssm1, sc1} !== {1'b0, 2'd1}) begin bad++; $display("FAIL prio_single: got %b want 001", {g_ssm1, sc1}); end
    lcm_req = 1'b1;
    tick();
    tick();
    total++; if ({g_lcm1, g_ssm1, rd1} !== 3'b100) begin bad++; $display("FAIL prio_regrant: got %b want 100", {g_lcm1, g_ssm1, rd1}); end
    send_pkt(4);
    total++; if (lc1 !== 2'd0) begin bad++; $display("FAIL prio_wrap: got %0d want 0", lc1); end
    lcm_req = 1'b0; ssm_req = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    lcm_req = 1'b1; ready = 1'b1;
    tick();
    total++; if (g_lcm0 !== 1'b1) begin bad++; $display("FAIL to_grant: got %b want 1", g_lcm0); end
    wr = 1'b1; tag = 2'b01;
    tick();
    wr = 1'b0; tag = 2'b00;
    lcm_req = 1'b0; ssm_req = 1'b1;
    for (int i = 1; i < 8; i++) begin
      total++; if ({to0, g_lcm0} !== 2'b01) begin bad++; $display("FAIL to_wait c%0d: got %b want 01", i, {to0, g_lcm0}); end
      tick();
    end
    total++; if ({to0, g_lcm0, lc0} !== {2'b10, 16'd0}) begin bad++; $display("FAIL to_fire: err/grant/cnt got %b/%b/%0d want 1/0/0", to0, g_lcm0, lc0); end
    tick();
    total++; if (to0 !== 1'b0) begin bad++; $display("FAIL to_pulse: got %b want 0", to0); end
    tick();
    total++; if ({g_lcm0, g_ssm0, rd0} !== 3'b011) begin bad++; $display("FAIL to_next_ssm: got %b want 011", {g_lcm0, g_ssm0, rd0}); end
    ssm_req = 1'b0;
    send_pkt(2);
  endtask

  task automatic test_reset_mid_pkt();
    do_reset();
    ssm_req = 1'b1; ready = 1'b1;
    tick();
    total++; if ({g_ssm0, rd0} !== 2'b11) begin bad++; $display("FAIL rm_grant: got %b want 11", {g_ssm0, rd0}); end
    ssm_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tag = (i == 0) ? 2'b01 : 2'b11;
      wr = 1'b1;
      tick();
    end
    wr = 1'b0; tag = 2'b00; rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if ({g_lcm0, g_ssm0, rd0, to0, st0, lc0, sc0} !== 37'b0) begin bad++; $display("FAIL rm_outputs: got %h want 0", {g_lcm0, g_ssm0, rd0, to0, st0, lc0, sc0}); end
    tick();
    wr = 1'b1; tag = 2'b10;
    tick();
    wr = 1'b0; tag = 2'b00;
    total++; if ({st0, g_lcm0, g_ssm0, sc0} !== {3'b100, 16'd0}) begin bad++; $display("FAIL rm_stray: got %b/%0d want 100/0", {st0, g_lcm0, g_ssm0}, sc0); end
    tick();
    total++; if (st0 !== 1'b0) begin bad++; $display("FAIL rm_stray_pulse: got %b want 0", st0); end
  endtask

  task automatic test_not_ready();
    do_reset();
    lcm_req = 1'b1; ssm_req = 1'b1; ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if ({g_lcm0, g_ssm0} !== 2'b00) begin bad++; $display("FAIL nr_hold c%0d: got %b want 00", i, {g_lcm0, g_ssm0}); end
    end
    ready = 1'b1;
    tick();
    total++; if ({g_lcm0, g_ssm0, rd0} !== 3'b100) begin bad++; $display("FAIL nr_grant: got %b want 100", {g_lcm0, g_ssm0, rd0}); end
    lcm_req = 1'b0; ssm_req = 1'b0;
    send_pkt(2);
  endtask

  initial begin
    test_reset();
    test_single_lcm();
    test_back_to_back();
    test_priority();
    test_timeout();
    test_reset_mid_pkt();
    test_not_ready();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
